// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared command codes, FSM states and widths for the console sequencer
// Purpose: common definitions imported by console_scroll_ctrl and console_fill_cnt.
// Ports: none (package).
package console_pkg;

  localparam int CELL_W = 20;  // {color[11:0], ascii[7:0]}
  localparam int ADDR_W = 13;  // display cell address
  localparam int ROW_W  = 6;   // row index width, ring buffer holds at most 64 rows

  localparam logic [1:0] CMD_NOP       = 2'b00;
  localparam logic [1:0] CMD_CLEAR     = 2'b01;
  localparam logic [1:0] CMD_SCROLL    = 2'b10;
  localparam logic [1:0] CMD_SET_START = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/console_fill_cnt.sv
// rtl/console_fill_cnt.sv - row/column walker that generates fill-engine cell addresses
// Purpose: steps through columns 0..COLS-1 of each row from a loaded start row up to
//          a loaded end row, producing the cell address and a last-cell flag.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load                load start/end rows and restart at column 0
//   load_row, load_end  first and last row of the fill
//   adv                 advance one cell (a write happened this cycle)
//   addr                current cell address (row << ROW_SHIFT | col)
//   last                current cell is the final cell of the fill
module console_fill_cnt
  import console_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int ROW_SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ROW_W-1:0]  load_row,
  input  logic [ROW_W-1:0]  load_end,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ROW_SHIFT-1:0] col;
  logic [ROW_W-1:0]     row;
  logic [ROW_W-1:0]     row_end;
  logic                 col_wrap;

  // Columns past COLS-1 are padding in the row stride and are never visited.
  assign col_wrap = (col == ROW_SHIFT'(COLS - 1));
  assign last     = col_wrap && (row == row_end);
  assign addr     = (ADDR_W'(row) << ROW_SHIFT) | ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      row_end <= '0;
    end else if (load) begin
      col     <= '0;
      row     <= load_row;
      row_end <= load_end;
    end else if (adv) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/console_scroll_ctrl.sv
// rtl/console_scroll_ctrl.sv - text console clear/scroll/start-line sequencer with shared write port
// Purpose: executes CLEAR, SCROLL and SET_START commands, fills display rows with
//          blank cells through the display memory write port (CPU writes always win),
//          and owns the start_line scroll register and a sticky error flag.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   cmd_valid, cmd_code, cmd_arg      command strobe, opcode and SET_START row
//   fill_color                        colour of filled cells, sampled at accept
//   cpu_we, cpu_addr, cpu_wdata       CPU display write (never stalled)
//   err_clr                           clears err
//   mem_we, mem_addr, mem_wdata       display memory write port
//   start_line                        top physical row shown
//   busy, done, err                   engine active, completion pulse, sticky error
module console_scroll_ctrl
  import console_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         NUM_ROWS  = 30,
  parameter int         ROW_SHIFT = 7,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_code,
  input  logic [7:0]        cmd_arg,
  input  logic [11:0]       fill_color,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [CELL_W-1:0] cpu_wdata,
  input  logic              err_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  output logic [7:0]        start_line,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [11:0]       color_q;
  logic [1:0]        op_q;
  logic              accept;
  logic              set_ok;
  logic              err_set;
  logic              eng_we;
  logic              eng_adv;
  logic              cnt_load;
  logic [ROW_W-1:0]  load_row;
  logic [ROW_W-1:0]  load_end;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;

  assign accept  = cmd_valid && (state == ST_IDLE);
  assign set_ok  = int'(cmd_arg) < NUM_ROWS;
  // Any command arriving while not idle is dropped and flagged.
  assign err_set = cmd_valid &&
                   ((state != ST_IDLE) || ((cmd_code == CMD_SET_START) && !set_ok));

  // The engine only advances on cycles the CPU leaves the port free.
  assign eng_we  = (state == ST_FILL);
  assign eng_adv = eng_we && !cpu_we;

  always_comb begin
    cnt_load = 1'b0;
    load_row = '0;
    load_end = '0;
    if (accept && (cmd_code == CMD_CLEAR)) begin
      cnt_load = 1'b1;
      load_end = ROW_W'(NUM_ROWS - 1);
    end else if (accept && (cmd_code == CMD_SCROLL)) begin
      // Scrolling blanks the current top row; it reappears as the new bottom row.
      cnt_load = 1'b1;
      load_row = start_line[ROW_W-1:0];
      load_end = start_line[ROW_W-1:0];
    end
  end

  console_fill_cnt #(
    .COLS      (COLS),
    .ROW_SHIFT (ROW_SHIFT)
  ) u_fill_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_row (load_row),
    .load_end (load_end),
    .adv      (eng_adv),
    .addr     (cnt_addr),
    .last     (cnt_last)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_we) begin
      mem_we    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (eng_we) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_addr;
      mem_wdata = {color_q, FILL_CHAR};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      start_line <= '0;
      color_q    <= '0;
      op_q       <= CMD_NOP;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_code)
              CMD_CLEAR, CMD_SCROLL: begin
                color_q <= fill_color;
                op_q    <= cmd_code;
                busy    <= 1'b1;
                state   <= ST_FILL;
              end
              CMD_SET_START: begin
                if (set_ok) begin
                  start_line <= cmd_arg;
                  op_q       <= cmd_code;
                  busy       <= 1'b1;
                  done       <= 1'b1;
                  state      <= ST_DONE;
                end
              end
              default: ;
            endcase
          end
        end
        ST_FILL: begin
          if (eng_adv && cnt_last) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start_line moves only here so a half-cleared top row is never displayed.
          if (op_q == CMD_CLEAR) begin
            start_line <= '0;
          end else if (op_q == CMD_SCROLL) begin
            start_line <= (start_line == 8'(NUM_ROWS - 1)) ? 8'd0 : start_line + 8'd1;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_console_scroll_ctrl.sv
// tb/tb_console_scroll_ctrl.sv - self-checking bench for console_scroll_ctrl
module tb_console_scroll_ctrl;
  import console_pkg::*;

  localparam int COLS      = 80;
  localparam int NUM_ROWS  = 30;
  localparam int ROW_SHIFT = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_code = 2'b00;
  logic [7:0]  cmd_arg = 8'd0;
  logic [11:0] fill_color = 12'd0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = 13'd0;
  logic [19:0] cpu_wdata = 20'd0;
  logic        err_clr = 1'b0;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [19:0] mem_wdata;
  logic [7:0]  start_line;
  logic        busy;
  logic        done;
  logic        err;

  console_scroll_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .fill_color(fill_color), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .err_clr(err_clr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .start_line(start_line), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit cpu_mode = 1'b0;

  // Observation counters (from DUT outputs) used by the literal checks.
  int eng_writes = 0;
  int done_pulses = 0;
  int fill_cycles = 0;
  int cpu_hits = 0;
  logic [12:0] first_addr = '0;
  logic [12:0] last_addr = '0;
  logic [19:0] last_data = '0;

  // Reference model: pending engine writes as a queue of cell addresses.
  int          q[$];
  int          m_phase;   // 0 idle, 1 filling, 2 done
  int          m_start;
  bit          m_err;
  logic [1:0]  m_pend;
  logic [11:0] m_color;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  task automatic fill_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++)
        q.push_back(r * (1 << ROW_SHIFT) + c);
  endtask

  initial begin
    logic        exp_we;
    logic [12:0] exp_addr;
    logic [19:0] exp_data;
    int          nph;
    bit          e_set;
    m_phase = 0; m_start = 0; m_err = 0; m_pend = CMD_NOP; m_color = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cpu_we) begin
        exp_we = 1'b1; exp_addr = cpu_addr; exp_data = cpu_wdata;
      end else if (m_phase == 1) begin
        exp_we = 1'b1; exp_addr = 13'(q[0]); exp_data = {m_color, 8'h20};
      end else begin
        exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      end
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(exp_data));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("start_line", 32'(start_line), 32'(m_start));
      chk("err", 32'(err), 32'(m_err));

      if (mem_we && !cpu_we) begin
        if (eng_writes == 0) first_addr = mem_addr;
        last_addr = mem_addr;
        last_data = mem_wdata;
        eng_writes++;
      end
      if (cpu_we && mem_we && mem_addr == 13'h0100 && mem_wdata == 20'hFFF41) cpu_hits++;
      if (done) done_pulses++;
      if (busy && !done) fill_cycles++;

      if (rst) begin
        q.delete();
        m_phase = 0; m_start = 0; m_err = 0; m_pend = CMD_NOP; m_color = '0;
      end else begin
        e_set = cmd_valid && (m_phase != 0 || (cmd_code == CMD_SET_START && int'(cmd_arg) >= NUM_ROWS));
        nph = m_phase;
        if (m_phase == 0) begin
          if (cmd_valid) begin
            if (cmd_code == CMD_CLEAR) begin
              fill_rows(0, NUM_ROWS - 1); m_color = fill_color; m_pend = CMD_CLEAR; nph = 1;
            end else if (cmd_code == CMD_SCROLL) begin
              fill_rows(m_start, m_start); m_color = fill_color; m_pend = CMD_SCROLL; nph = 1;
            end else if (cmd_code == CMD_SET_START && int'(cmd_arg) < NUM_ROWS) begin
              m_start = int'(cmd_arg); m_pend = CMD_SET_START; nph = 2;
            end
          end
        end else if (m_phase == 1) begin
          if (!cpu_we) begin
            void'(q.pop_front());
            if (q.size() == 0) nph = 2;
          end
        end else begin
          if (m_pend == CMD_CLEAR) m_start = 0;
          else if (m_pend == CMD_SCROLL) m_start = (m_start + 1) % NUM_ROWS;
          nph = 0;
        end
        if (e_set) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_phase = nph;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    err_clr = 1'b0;
    if (cpu_mode && $urandom_range(7) == 0) begin
      cpu_we = 1'b1; cpu_addr = 13'($urandom); cpu_wdata = 20'($urandom);
    end else begin
      cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [11:0] col);
    cycle();
    cmd_valid = 1'b1; cmd_code = c; cmd_arg = a; fill_color = col;
  endtask

  task automatic clr_counts();
    eng_writes = 0; done_pulses = 0; fill_cycles = 0; cpu_hits = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    cycle();
    while (busy && n < limit) begin
      cycle();
      n++;
    end
    if (busy) begin
      checks++;
      $display("FAIL wait_idle timeout after %0d cycles, busy still %0b", n, busy);
    end
  endtask

  initial begin
    int n;
    int r;
    logic [1:0] c;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    #2;
    chk("rst_start_line", 32'(start_line), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);

    // Full clear.
    clr_counts();
    issue(CMD_CLEAR, 8'd0, 12'h0F0);
    cycle();
    #1;
    chk("clear_busy_next", 32'(busy), 32'd1);
    wait_idle(3000);
    chk("clear_writes", 32'(eng_writes), 32'd2400);
    chk("clear_first", 32'(first_addr), 32'h0000);
    chk("clear_last", 32'(last_addr), 32'h0ECF);
    chk("clear_data", 32'(last_data), 32'h0F020);
    chk("clear_done", 32'(done_pulses), 32'd1);
    chk("clear_start", 32'(start_line), 32'd0);

    // SET_START 29 then SCROLL wraps to 0.
    issue(CMD_SET_START, 8'd29, 12'h000);
    wait_idle(10);
    chk("set29_start", 32'(start_line), 32'd29);
    clr_counts();
    issue(CMD_SCROLL, 8'd0, 12'h345);
    wait_idle(200);
    chk("scroll_writes", 32'(eng_writes), 32'd80);
    chk("scroll_first", 32'(first_addr), 32'h0E80);
    chk("scroll_last", 32'(last_addr), 32'h0ECF);
    chk("scroll_wrap", 32'(start_line), 32'd0);

    // SCROLL with five CPU collisions.
    clr_counts();
    issue(CMD_SCROLL, 8'd0, 12'h123);
    for (int k = 1; k <= 200; k++) begin
      cycle();
      if (!busy) break;
      if (k == 2 || k == 11 || k == 30 || k == 47 || k == 66) begin
        cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 20'hFFF41;
      end
    end
    chk("coll_writes", 32'(eng_writes), 32'd80);
    chk("coll_fill_cycles", 32'(fill_cycles), 32'd85);
    chk("coll_cpu_hits", 32'(cpu_hits), 32'd5);
    chk("coll_start", 32'(start_line), 32'd1);

    // Error paths.
    clr_counts();
    issue(CMD_SET_START, 8'd30, 12'h000);
    cycle();
    #1;
    chk("set30_err", 32'(err), 32'd1);
    chk("set30_start", 32'(start_line), 32'd1);
    chk("set30_busy", 32'(busy), 32'd0);
    cycle();
    chk("set30_nodone", 32'(done_pulses), 32'd0);
    err_clr = 1'b1;
    cycle();
    #1;
    chk("errclr", 32'(err), 32'd0);
    clr_counts();
    issue(CMD_CLEAR, 8'd0, 12'h00F);
    repeat (100) cycle();
    cmd_valid = 1'b1; cmd_code = CMD_SCROLL;
    cycle();
    #1;
    chk("busy_cmd_err", 32'(err), 32'd1);
    wait_idle(3000);
    chk("busy_cmd_writes", 32'(eng_writes), 32'd2400);
    chk("busy_cmd_done", 32'(done_pulses), 32'd1);
    chk("busy_cmd_start", 32'(start_line), 32'd0);

    // Reset in the middle of a clear.
    issue(CMD_SET_START, 8'd7, 12'h000);
    wait_idle(10);
    clr_counts();
    issue(CMD_CLEAR, 8'd0, 12'hABC);
    n = 0;
    while (eng_writes < 999 && n < 5000) begin
      cycle();
      n++;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("abort_writes", 32'(eng_writes), 32'd1000);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_start", 32'(start_line), 32'd0);
    clr_counts();
    issue(CMD_SCROLL, 8'd0, 12'h777);
    wait_idle(200);
    chk("post_abort_writes", 32'(eng_writes), 32'd80);
    chk("post_abort_first", 32'(first_addr), 32'h0000);
    chk("post_abort_start", 32'(start_line), 32'd1);

    // Randomized traffic, checked cycle by cycle against the model.
    cpu_mode = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      cycle();
      r = int'($urandom_range(59));
      if (r == 0) begin
        c = 2'($urandom_range(3));
        if (c == CMD_CLEAR && $urandom_range(3) != 0) c = CMD_SCROLL;
        cmd_valid = 1'b1; cmd_code = c;
        cmd_arg = 8'($urandom_range(40)); fill_color = 12'($urandom);
      end else if (r == 1) begin
        err_clr = 1'b1;
      end
    end
    cpu_mode = 1'b0;
    wait_idle(3000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/console_scroll_ctrl.md
Name: console_scroll_ctrl

Overview:
- Text-console sequencer for the character display memory write port (20-bit cells: {color[11:0], ascii[7:0]}) and the start_line scroll register.
- Executes CPU-issued commands: CLEAR screen, SCROLL one line, SET start line.
- Shares the single display-memory write port between the CPU (0x002 region) and its internal fill engine; CPU always has priority.
- Sits between the CPU bus decode and DisplayMem; drives start_line to both Display and DisplayMem.

Parameters:
- COLS, 80, visible characters per row.
- NUM_ROWS, 30, rows in the ring buffer (≤ 64).
- ROW_SHIFT, 7, log2 of the row stride in cells (address = row<<ROW_SHIFT | col).
- FILL_CHAR, 8'h20, ASCII code written by fill operations.

Ports:
- clk  in  1  system clock (CPU clock domain).
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command strobe, one cycle.
- cmd_code  in  2  00 NOP, 01 CLEAR, 10 SCROLL, 11 SET_START.
- cmd_arg  in  8  SET_START target row.
- fill_color  in  12  colour for filled cells; sampled at command accept.
- cpu_we  in  1  CPU display write.
- cpu_addr  in  13  CPU display cell address.
- cpu_wdata  in  20  CPU cell data.
- err_clr  in  1  clears err.
- mem_we  out  1  display memory write enable.
- mem_addr  out  13  display memory write address.
- mem_wdata  out  20  display memory write data.
- start_line  out  8  top physical row shown.
- busy  out  1  engine active; also means not ready.
- done  out  1  one-cycle pulse on command completion.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: start_line=0, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0. State=IDLE.
- Reset asserted mid-fill aborts the operation. Cells already written keep their contents; later cells are not written.
- Port mux is combinational and has zero latency.
  - If cpu_we=1: mem_* = cpu_*. The engine issues no write that cycle and does not advance its counter.
  - Else: mem_we is the engine's write enable and mem_addr/mem_wdata come from the engine.
  - CPU writes are never stalled or dropped, including during busy.
- States: IDLE, FILL, DONE.
- IDLE, cmd_valid=1:
  - NOP: no action; no done pulse.
  - CLEAR: latch row_cnt=0, row_end=NUM_ROWS-1, colour; go to FILL.
  - SCROLL: latch row_cnt=row_end=start_line; go to FILL.
  - SET_START, cmd_arg<NUM_ROWS: start_line←cmd_arg next cycle; go to DONE.
  - SET_START, cmd_arg≥NUM_ROWS: err←1; start_line unchanged; stay IDLE; no done.
- busy=1 from the cycle after accept until DONE is left. cmd_valid while busy is ignored and sets err.
- FILL:
  - Each non-CPU cycle writes {fill_color_latched, FILL_CHAR} to (row_cnt<<ROW_SHIFT)|col_cnt, then col_cnt++.
  - At col_cnt=COLS-1: col_cnt←0 and row_cnt++. If row_cnt=row_end, go to DONE.
  - Columns COLS..stride-1 are never written.
  - First engine write may occur in the cycle after accept.
  - CLEAR takes NUM_ROWS*COLS engine writes plus one cycle per CPU-write collision. SCROLL takes COLS writes.
- DONE (one cycle): done=1, busy=1, then IDLE.
  - CLEAR: start_line←0.
  - SCROLL: start_line←(start_line==NUM_ROWS-1)?0:start_line+1 (wrap-around). The cleared row becomes the new bottom row.
  - start_line changes only in DONE (or on reset), so the display never shows a half-cleared top row.
- A command accepted in the same cycle as DONE is not possible: busy is still 1, so such a command is ignored and sets err.
- err: sticky. err_clr=1 clears it; if clear and set occur in the same cycle, set wins.

Decomposition:
- Shared package console_pkg:
  - cmd_code localparams CMD_NOP/CMD_CLEAR/CMD_SCROLL/CMD_SET_START.
  - State encoding ST_IDLE/ST_FILL/ST_DONE.
  - CELL_W=20, ADDR_W=13.
- One sub-module: console_fill_cnt. Row/column counter with advance enable, COLS wrap, row_end compare, last flag and address output. The top level holds the FSM, the port mux, and start_line/err.

Test Plan:
- Reset, then CLEAR with fill_color=12'h0F0 → busy from next cycle; exactly 2400 writes of 20'h0F020, covering addr 0x0000–0x004F … 0x0E80–0x0ECF; then one done pulse; start_line=0.
- SET_START arg=29, then SCROLL → 80 writes to 0x0E80–0x0ECF; start_line 29→0 at done (wrap-around).
- SCROLL with cpu_we=1 on 5 scattered cycles (cpu_addr=0x0100, cpu_wdata=20'hFFF41) → those cycles show the CPU write on mem_*; engine still completes 80 writes; total FILL length 85 cycles; no cell skipped or duplicated.
- SET_START arg=30 → err=1, start_line unchanged, no done. err_clr → err=0. CLEAR then a SCROLL mid-fill → err=1 and the SCROLL is ignored.
- rst asserted at engine write #1000 of a CLEAR → next cycle mem_we=0, busy=0, start_line=0; a subsequent SCROLL runs normally.
